module_encoder: RTL and testbench

MODULE_ENCODER -- requirements
Module: module_encoder

---
 rtl/module_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_module_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_encoder.sv
// module_encoder: serialises a TBM/ROC readout frame into a 4-bit nibble stream.
//
// A frame is a TBM header, nroc ROC blocks and a TBM trailer. Each ROC block is
// a ROC header followed by any number of 6-nibble pixel words. The block ends
// when an end-of-ROC entry arrives from the hit source. The stream advances one
// nibble per ena strobe. When the hit source has nothing ready at a decision
// point, the encoder sends IDLE_NIB stall nibbles and sets a sticky underrun flag.
//
// Ports
//   clk80         in   clock, rising edge
//   reset         in   synchronous, active-high reset
//   ena           in   nibble strobe
//   start         in   frame request, accepted only while busy=0
//   tbm_hdr_data  in   16-bit TBM header payload, captured on an accepted start
//   tbm_trl_data  in   16-bit TBM trailer payload, captured on an accepted start
//   nroc          in   number of ROC blocks (0..15), captured on an accepted start
//   roc_bits      in   ROC header status bits, captured on an accepted start
//   hit_valid     in   hit entry available
//   hit_eor       in   entry is an end-of-ROC marker
//   hit_data      in   24-bit pixel word, sent MSB nibble first
//   hit_ready     out  entry consumed this cycle (decision slot)
//   dout          out  registered nibble stream
//   busy          out  frame in progress
//   done          out  one-cycle pulse after the frame ends
//   underrun      out  sticky: an entry was needed while hit_valid=0
module module_encoder #(
    parameter logic [3:0] IDLE_NIB = 4'b1111
) (
    input  logic        clk80,
    input  logic        reset,
    input  logic        ena,
    input  logic        start,
    input  logic [15:0] tbm_hdr_data,
    input  logic [15:0] tbm_trl_data,
    input  logic [3:0]  nroc,
    input  logic [1:0]  roc_bits,
    input  logic        hit_valid,
    input  logic        hit_eor,
    input  logic [23:0] hit_data,
    output logic        hit_ready,
    output logic [3:0]  dout,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TH   = 3'd1;
    localparam logic [2:0] S_RH   = 3'd2;
    localparam logic [2:0] S_PX   = 3'd3;
    localparam logic [2:0] S_TT   = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;

    // TBM header/trailer: 0111, 1111, identifier nibble, then 16-bit payload.
    function automatic logic [3:0] tbm_nib(input logic [2:0] idx,
                                           input logic [3:0] id_nib,
                                           input logic [15:0] data);
        case (idx)
            3'd0:    tbm_nib = 4'h7;
            3'd1:    tbm_nib = 4'hF;
            3'd2:    tbm_nib = id_nib;
            3'd3:    tbm_nib = data[15:12];
            3'd4:    tbm_nib = data[11:8];
            3'd5:    tbm_nib = data[7:4];
            default: tbm_nib = data[3:0];
        endcase
    endfunction

    function automatic logic [3:0] rh_nib(input logic [2:0] idx, input logic [1:0] bits);
        case (idx)
            3'd0:    rh_nib = 4'h7;
            3'd1:    rh_nib = 4'hF;
            default: rh_nib = {2'b10, bits};
        endcase
    endfunction

    function automatic logic [3:0] pix_nib(input logic [2:0] idx, input logic [23:0] pix);
        case (idx)
            3'd0:    pix_nib = pix[23:20];
            3'd1:    pix_nib = pix[19:16];
            3'd2:    pix_nib = pix[15:12];
            3'd3:    pix_nib = pix[11:8];
            3'd4:    pix_nib = pix[7:4];
            default: pix_nib = pix[3:0];
        endcase
    endfunction

    logic [2:0]  state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic [3:0]  roc_cnt, roc_cnt_d;
    logic [3:0]  dout_d;
    logic        busy_d, done_d, underrun_d;
    logic        latch, pix_ld, decision;

    // Frame fields captured on the accepted start; pixel word captured on consume.
    logic [15:0] hdr_p0, trl_p0;
    logic [3:0]  nroc_p0;
    logic [1:0]  bits_p0;
    logic [23:0] pix_p0;

    // A decision slot is the ena cycle after the last RH/PX nibble was loaded,
    // or any ena cycle spent stalled in WAIT.
    assign decision = ena && !reset &&
                      ((state == S_RH && cnt == 3'd2) ||
                       (state == S_PX && cnt == 3'd5) ||
                       (state == S_WAIT));
    assign hit_ready = decision;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        roc_cnt_d  = roc_cnt;
        dout_d     = dout;
        busy_d     = busy;
        done_d     = 1'b0;
        underrun_d = underrun;
        latch      = 1'b0;
        pix_ld     = 1'b0;
        if (state == S_IDLE) begin
            // IDLE with busy=1 means a frame is armed; its first nibble waits
            // for an ena strictly after the start cycle.
            if (!busy) begin
                if (start) begin
                    latch      = 1'b1;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
                end
            end else if (ena) begin
                state_d = S_TH;
                cnt_d   = 3'd0;
                dout_d  = 4'h7;
            end
        end else if (ena) begin
            case (state)
                S_TH: begin
                    if (cnt != 3'd6) begin
                        cnt_d  = cnt + 3'd1;
                        dout_d = tbm_nib(cnt + 3'd1, 4'hC, hdr_p0);
                    end else begin
                        cnt_d     = 3'd0;
                        dout_d    = 4'h7;
                        roc_cnt_d = nroc_p0;
                        state_d   = (nroc_p0 != 4'd0) ? S_RH : S_TT;
                    end
                end
                S_RH: begin
                    if (cnt != 3'd2) begin
                        cnt_d  = cnt + 3'd1;
                        dout_d = rh_nib(cnt + 3'd1, bits_p0);
                    end
                end
                S_PX: begin
                    if (cnt != 3'd5) begin
                        cnt_d  = cnt + 3'd1;
                        dout_d = pix_nib(cnt + 3'd1, pix_p0);
                    end
                end
                S_TT: begin
                    if (cnt != 3'd6) begin
                        cnt_d  = cnt + 3'd1;
                        dout_d = tbm_nib(cnt + 3'd1, 4'hE, trl_p0);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        dout_d  = IDLE_NIB;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (decision) begin
                cnt_d = 3'd0;
                if (!hit_valid) begin
                    state_d    = S_WAIT;
                    dout_d     = IDLE_NIB;
                    underrun_d = 1'b1;
                end else if (!hit_eor) begin
                    state_d = S_PX;
                    dout_d  = hit_data[23:20];
                    pix_ld  = 1'b1;
                end else begin
                    roc_cnt_d = roc_cnt - 4'd1;
                    dout_d    = 4'h7;
                    state_d   = (roc_cnt > 4'd1) ? S_RH : S_TT;
                end
            end
        end
    end

    always_ff @(posedge clk80) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            roc_cnt  <= 4'd0;
            dout     <= IDLE_NIB;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            roc_cnt  <= roc_cnt_d;
            dout     <= dout_d;
            busy     <= busy_d;
            done     <= done_d;
            underrun <= underrun_d;
        end
    end

    always_ff @(posedge clk80) begin
        if (latch) begin
            hdr_p0  <= tbm_hdr_data;
            trl_p0  <= tbm_trl_data;
            nroc_p0 <= nroc;
            bits_p0 <= roc_bits;
        end
        if (pix_ld) begin
            pix_p0 <= hit_data;
        end
    end

endmodule

// File: tb/tb_module_encoder.sv
// Directed testbench for module_encoder.
module tb_module_encoder;

    logic        clk80 = 1'b0;
    logic        reset, ena, start;
    logic [15:0] tbm_hdr_data, tbm_trl_data;
    logic [3:0]  nroc;
    logic [1:0]  roc_bits;
    logic        hit_valid, hit_eor;
    logic [23:0] hit_data;
    logic        hit_ready;
    logic [3:0]  dout;
    logic        busy, done, underrun;

    always #5 clk80 = ~clk80;

    module_encoder #(.IDLE_NIB(4'b1111)) dut (
        .clk80(clk80), .reset(reset), .ena(ena), .start(start),
        .tbm_hdr_data(tbm_hdr_data), .tbm_trl_data(tbm_trl_data),
        .nroc(nroc), .roc_bits(roc_bits),
        .hit_valid(hit_valid), .hit_eor(hit_eor), .hit_data(hit_data),
        .hit_ready(hit_ready), .dout(dout), .busy(busy), .done(done),
        .underrun(underrun)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [23:0] d;
    } hit_t;

    hit_t        hq[$];
    logic [3:0]  cap_q[$];
    logic        cap_u[$];
    int          n_ready, n_done, hold_err;
    bit          timed_out;
    logic        start_under, start_busy;

    logic [3:0] exp_nroc0[$] = '{4'h7, 4'hF, 4'hC, 4'hA, 4'h5, 4'h5, 4'hA,
                                 4'h7, 4'hF, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
    logic [3:0] exp_pix[$]   = '{4'h7, 4'hF, 4'hC, 4'hA, 4'h5, 4'h5, 4'hA,
                                 4'h7, 4'hF, 4'h9,
                                 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'hF, 4'h9,
                                 4'h7, 4'hF, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
    logic [3:0] exp_under[$] = '{4'h7, 4'hF, 4'hC, 4'hA, 4'h5, 4'h5, 4'hA,
                                 4'h7, 4'hF, 4'h9,
                                 4'hF, 4'hF, 4'hF,
                                 4'h7, 4'hF, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};

    task automatic setup(input logic [3:0] n, input logic [1:0] bits);
        tbm_hdr_data = 16'hA55A;
        tbm_trl_data = 16'h1234;
        nroc         = n;
        roc_bits     = bits;
    endtask

    // Runs one frame from a start pulse, recording every nibble loaded by an
    // ena edge until done, plus hit_ready/done activity. ena_mode 1 toggles ena.
    task automatic run_frame(input int ena_mode, input int start2, input int max_cyc);
        int         cyc;
        int         post;
        bit         fin;
        logic       ena_pre, pop_pre;
        logic [3:0] prev;
        cap_q.delete();
        cap_u.delete();
        n_ready = 0; n_done = 0; hold_err = 0; timed_out = 0;
        cyc = 0; post = 0; fin = 0;
        while (1) begin
            start = (cyc == 0) || (cyc == start2);
            ena   = (ena_mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (cyc == start2) begin
                nroc         = 4'd5;
                tbm_hdr_data = 16'hFFFF;
            end
            if (hq.size() > 0) begin
                hit_valid = hq[0].v; hit_eor = hq[0].e; hit_data = hq[0].d;
            end else begin
                hit_valid = 1'b0; hit_eor = 1'b0; hit_data = 24'h0;
            end
            #1;
            ena_pre = ena;
            pop_pre = hit_ready;
            prev    = dout;
            if (hit_ready) n_ready++;
            @(posedge clk80); #1;
            if (pop_pre && hq.size() > 0) void'(hq.pop_front());
            if (cyc == 0) begin
                start_under = underrun;
                start_busy  = busy;
            end else if (!fin) begin
                if (ena_pre) begin
                    cap_q.push_back(dout);
                    cap_u.push_back(underrun);
                end else if (dout !== prev) begin
                    hold_err++;
                end
            end
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (fin) post++;
            cyc++;
            if (post > 6) break;
            if (cyc > max_cyc) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0; ena = 1'b1; hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ena = 1'b1; start = 1'b0; hit_valid = 1'b1; hit_eor = 1'b0;
        repeat (2) @(posedge clk80);
        #1;
        vec_cnt++; if (dout !== 4'hF) begin err_cnt++; $display("FAIL reset_dout got %h want F", dout); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL reset_underrun got %b want 0", underrun); end
        vec_cnt++; if (hit_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_hit_ready got %b want 0", hit_ready); end
        reset = 1'b0;
        @(posedge clk80); #1;
        vec_cnt++; if (hit_ready !== 1'b0) begin err_cnt++; $display("FAIL idle_hit_ready got %b want 0", hit_ready); end
        vec_cnt++; if (dout !== 4'hF) begin err_cnt++; $display("FAIL idle_dout got %h want F", dout); end
        hit_valid = 1'b0;
    endtask

    task automatic test_nroc0();
        setup(4'd0, 2'b00);
        hq.delete();
        run_frame(0, -1, 200);
        vec_cnt++; if (timed_out) begin err_cnt++; $display("FAIL nroc0_timeout got timeout want done"); end
        vec_cnt++; if (start_busy !== 1'b1) begin err_cnt++; $display("FAIL nroc0_busy got %b want 1", start_busy); end
        for (int i = 0; i < exp_nroc0.size(); i++) begin
            vec_cnt++;
            if (i >= cap_q.size()) begin err_cnt++; $display("FAIL nroc0_nib[%0d] got none want %h", i, exp_nroc0[i]); end
            else if (cap_q[i] !== exp_nroc0[i]) begin err_cnt++; $display("FAIL nroc0_nib[%0d] got %h want %h", i, cap_q[i], exp_nroc0[i]); end
        end
        vec_cnt++; if (cap_q.size() != exp_nroc0.size()) begin err_cnt++; $display("FAIL nroc0_len got %0d want %0d", cap_q.size(), exp_nroc0.size()); end
        vec_cnt++; if (n_done != 1) begin err_cnt++; $display("FAIL nroc0_done got %0d want 1", n_done); end
        vec_cnt++; if (n_ready != 0) begin err_cnt++; $display("FAIL nroc0_ready got %0d want 0", n_ready); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL nroc0_busy_end got %b want 0", busy); end
    endtask

    task automatic test_pixels(input int ena_mode);
        setup(4'd2, 2'b01);
        hq.delete();
        hq.push_back('{1'b1, 1'b0, 24'h123456});
        hq.push_back('{1'b1, 1'b1, 24'h0});
        hq.push_back('{1'b1, 1'b1, 24'h0});
        run_frame(ena_mode, -1, 400);
        vec_cnt++; if (timed_out) begin err_cnt++; $display("FAIL pix%0d_timeout got timeout want done", ena_mode); end
        for (int i = 0; i < exp_pix.size(); i++) begin
            vec_cnt++;
            if (i >= cap_q.size()) begin err_cnt++; $display("FAIL pix%0d_nib[%0d] got none want %h", ena_mode, i, exp_pix[i]); end
            else if (cap_q[i] !== exp_pix[i]) begin err_cnt++; $display("FAIL pix%0d_nib[%0d] got %h want %h", ena_mode, i, cap_q[i], exp_pix[i]); end
        end
        vec_cnt++; if (cap_q.size() != exp_pix.size()) begin err_cnt++; $display("FAIL pix%0d_len got %0d want %0d", ena_mode, cap_q.size(), exp_pix.size()); end
        vec_cnt++; if (n_ready != 3) begin err_cnt++; $display("FAIL pix%0d_ready got %0d want 3", ena_mode, n_ready); end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL pix%0d_underrun got %b want 0", ena_mode, underrun); end
        vec_cnt++; if (n_done != 1) begin err_cnt++; $display("FAIL pix%0d_done got %0d want 1", ena_mode, n_done); end
        vec_cnt++; if (hold_err != 0) begin err_cnt++; $display("FAIL pix%0d_hold got %0d changes want 0", ena_mode, hold_err); end
    endtask

    task automatic test_underrun();
        setup(4'd1, 2'b01);
        hq.delete();
        hq.push_back('{1'b0, 1'b0, 24'h0});
        hq.push_back('{1'b0, 1'b0, 24'h0});
        hq.push_back('{1'b0, 1'b0, 24'h0});
        hq.push_back('{1'b1, 1'b1, 24'h0});
        run_frame(0, -1, 200);
        vec_cnt++; if (timed_out) begin err_cnt++; $display("FAIL under_timeout got timeout want done"); end
        for (int i = 0; i < exp_under.size(); i++) begin
            vec_cnt++;
            if (i >= cap_q.size()) begin err_cnt++; $display("FAIL under_nib[%0d] got none want %h", i, exp_under[i]); end
            else if (cap_q[i] !== exp_under[i]) begin err_cnt++; $display("FAIL under_nib[%0d] got %h want %h", i, cap_q[i], exp_under[i]); end
        end
        if (cap_u.size() > 10) begin
            vec_cnt++; if (cap_u[9] !== 1'b0) begin err_cnt++; $display("FAIL under_flag_before got %b want 0", cap_u[9]); end
            vec_cnt++; if (cap_u[10] !== 1'b1) begin err_cnt++; $display("FAIL under_flag_first_stall got %b want 1", cap_u[10]); end
        end else begin
            vec_cnt++; err_cnt++; $display("FAIL under_flag_samples got %0d want >10", cap_u.size());
        end
        vec_cnt++; if (n_ready != 4) begin err_cnt++; $display("FAIL under_ready got %0d want 4", n_ready); end
        vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL under_sticky got %b want 1", underrun); end
        // The next accepted start clears the flag.
        setup(4'd0, 2'b00);
        hq.delete();
        run_frame(0, -1, 200);
        vec_cnt++; if (start_under !== 1'b0) begin err_cnt++; $display("FAIL under_clear got %b want 0", start_under); end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL under_clear_end got %b want 0", underrun); end
    endtask

    task automatic test_reset_mid();
        setup(4'd1, 2'b01);
        hq.delete();
        hit_valid = 1'b1; hit_eor = 1'b0; hit_data = 24'h123456;
        ena = 1'b1; start = 1'b1;
        @(posedge clk80); #1;
        start = 1'b0;
        repeat (14) @(posedge clk80);
        #1;
        vec_cnt++; if (dout !== 4'h4) begin err_cnt++; $display("FAIL mid_px3 got %h want 4", dout); end
        reset = 1'b1;
        @(posedge clk80); #1;
        vec_cnt++; if (dout !== 4'hF) begin err_cnt++; $display("FAIL mid_reset_dout got %h want F", dout); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_done got %b want 0", done); end
        reset = 1'b0; hit_valid = 1'b0;
        @(posedge clk80); #1;
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL mid_after_done got %b want 0", done); end
        setup(4'd0, 2'b00);
        run_frame(0, -1, 200);
        for (int i = 0; i < exp_nroc0.size(); i++) begin
            vec_cnt++;
            if (i >= cap_q.size()) begin err_cnt++; $display("FAIL mid_nib[%0d] got none want %h", i, exp_nroc0[i]); end
            else if (cap_q[i] !== exp_nroc0[i]) begin err_cnt++; $display("FAIL mid_nib[%0d] got %h want %h", i, cap_q[i], exp_nroc0[i]); end
        end
        vec_cnt++; if (n_done != 1) begin err_cnt++; $display("FAIL mid_done got %0d want 1", n_done); end
    endtask

    task automatic test_start_in_tt();
        setup(4'd0, 2'b00);
        hq.delete();
        run_frame(0, 10, 200);
        for (int i = 0; i < exp_nroc0.size(); i++) begin
            vec_cnt++;
            if (i >= cap_q.size()) begin err_cnt++; $display("FAIL tt_start_nib[%0d] got none want %h", i, exp_nroc0[i]); end
            else if (cap_q[i] !== exp_nroc0[i]) begin err_cnt++; $display("FAIL tt_start_nib[%0d] got %h want %h", i, cap_q[i], exp_nroc0[i]); end
        end
        vec_cnt++; if (n_done != 1) begin err_cnt++; $display("FAIL tt_start_done got %0d want 1", n_done); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL tt_start_busy got %b want 0", busy); end
        vec_cnt++; if (dout !== 4'hF) begin err_cnt++; $display("FAIL tt_start_idle got %h want F", dout); end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; start = 1'b0;
        hit_valid = 1'b0; hit_eor = 1'b0; hit_data = 24'h0;
        setup(4'd0, 2'b00);
        test_reset();
        test_nroc0();
        test_pixels(0);
        test_pixels(1);
        test_underrun();
        test_reset_mid();
        test_start_in_tt();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
